// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexed seven-segment digit scanner with PWM dimming, blinking and
// optional leading-zero suppression (define SEVEN_SEG_LZS_EN to enable suppression).
module seven_seg_scanner #(
  parameter int DISPLAY_COUNT = 4,
  parameter int DATA_SIZE = 4,
  parameter int SCAN_DIV = 256,
  parameter int PWM_BITS = 4,
  parameter int BLINK_FRAMES = 50
) (
  input logic clk_disp,
  input logic reset,
  input logic [DATA_SIZE*DISPLAY_COUNT-1:0] values,
  input logic [DISPLAY_COUNT-1:0] display_enable,
  input logic [DISPLAY_COUNT-1:0] dp_in,
  input logic [DISPLAY_COUNT-1:0] blink_mask,
  input logic [PWM_BITS-1:0] brightness,
  output logic [DATA_SIZE-1:0] selected,
  output logic dp_out,
  output logic [DISPLAY_COUNT-1:0] enable,
  output logic [(DISPLAY_COUNT > 1 ? $clog2(DISPLAY_COUNT) : 1)-1:0] digit_idx,
  output logic frame_start
);
  localparam int IW = DISPLAY_COUNT > 1 ? $clog2(DISPLAY_COUNT) : 1;
  localparam int STEP = SCAN_DIV >> PWM_BITS;
  localparam int SW = STEP > 1 ? $clog2(STEP) : 1;
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  // The slot counter is kept split as (phase, sub_cnt) so the PWM phase needs no divider.
  logic [SW-1:0] sub_cnt;
  logic [PWM_BITS-1:0] phase;
  logic [FW-1:0] frame_cnt;
  logic blink_phase;
  logic sub_end, slot_end, last, frame_end, lit;
  logic [DISPLAY_COUNT-1:0] supp, lit_mask;
`ifdef SEVEN_SEG_LZS_EN
  logic [DISPLAY_COUNT:0] zero_up;
  assign zero_up[DISPLAY_COUNT] = 1'b1;
  for (genvar g = 0; g < DISPLAY_COUNT; g++) begin : g_lzs
    assign zero_up[g] = ~|values[g*DATA_SIZE +: DATA_SIZE] & zero_up[g+1];
  end
  assign supp = zero_up[DISPLAY_COUNT-1:0] & ~DISPLAY_COUNT'(1);
`else
  assign supp = '0;
`endif
  assign sub_end = sub_cnt == SW'(STEP - 1);
  assign slot_end = sub_end && &phase;
  assign last = digit_idx == IW'(DISPLAY_COUNT - 1);
  assign frame_end = slot_end && last;
  assign lit_mask = display_enable & ~(blink_mask & {DISPLAY_COUNT{blink_phase}}) & ~supp;
  assign lit = lit_mask[digit_idx] && phase <= brightness;
  // Scan counters, blink timing and registered digit drive.
  always_ff @(posedge clk_disp or posedge reset) begin
    if (reset) begin
      sub_cnt <= '0;
      phase <= '0;
      digit_idx <= '0;
      frame_cnt <= '0;
      blink_phase <= 1'b0;
      selected <= '0;
      dp_out <= 1'b0;
      enable <= '1;
      frame_start <= 1'b0;
    end else begin
      sub_cnt <= sub_end ? '0 : sub_cnt + 1'b1;
      if (sub_end) phase <= phase + 1'b1;
      if (slot_end) digit_idx <= last ? '0 : digit_idx + 1'b1;
      if (frame_end) begin
        frame_cnt <= frame_cnt == FW'(BLINK_FRAMES - 1) ? '0 : frame_cnt + 1'b1;
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) blink_phase <= ~blink_phase;
      end
      selected <= values[digit_idx*DATA_SIZE +: DATA_SIZE];
      dp_out <= dp_in[digit_idx] & lit;
      enable <= lit ? ~(DISPLAY_COUNT'(1) << digit_idx) : '1;
      frame_start <= frame_end;
    end
  end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed checks of scanning, PWM, blink, reset and digit gating.
module tb_seven_seg_scanner;
  logic clk_disp = 1'b0;
  logic reset = 1'b1;
  logic [15:0] values = 16'h4321;
  logic [3:0] display_enable = 4'b1111;
  logic [3:0] dp_in = 4'b0001;
  logic [3:0] blink_mask = 4'b0010;
  logic [3:0] brightness = 4'd15;
  logic [3:0] selected;
  logic dp_out;
  logic [3:0] enable;
  logic [1:0] digit_idx;
  logic frame_start;
  int k = 0;
  int total = 0;
  int bad = 0;
  seven_seg_scanner #(.BLINK_FRAMES(2)) dut (
    .clk_disp(clk_disp),
    .reset(reset),
    .values(values),
    .display_enable(display_enable),
    .dp_in(dp_in),
    .blink_mask(blink_mask),
    .brightness(brightness),
    .selected(selected),
    .dp_out(dp_out),
    .enable(enable),
    .digit_idx(digit_idx),
    .frame_start(frame_start)
  );
  always #5 clk_disp = ~clk_disp;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at k=%0d: got %0h expected %0h", tag, k, got, exp);
    end
  endtask
  // Advance to the falling edge that follows the t-th rising edge since reset release.
  task automatic go(input int t);
    while (k < t) begin
      @(negedge clk_disp);
      k++;
    end
  endtask
  initial begin
    repeat (3) @(negedge clk_disp);
    chk("rst_en", enable, 4'b1111);
    chk("rst_sel", selected, 0);
    chk("rst_dp", dp_out, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_idx", digit_idx, 0);
    reset = 1'b0;
    k = 0;
    go(1);    chk("d0_en", enable, 4'b1110); chk("d0_sel", selected, 1); chk("d0_dp", dp_out, 1);
    go(256);  chk("d0_end", enable, 4'b1110);
    go(257);  chk("d1_en", enable, 4'b1101); chk("d1_sel", selected, 2); chk("d1_dp", dp_out, 0);
    go(769);  chk("d3_en", enable, 4'b0111); chk("d3_sel", selected, 4);
    go(1023); chk("fs_pre", frame_start, 0);
    go(1024); chk("fs", frame_start, 1);
    go(1025); chk("fs_post", frame_start, 0); chk("f1_d0", enable, 4'b1110);
    go(1281); chk("blink_f1", enable, 4'b1101);
    go(2049); chk("blink_f2_d0", enable, 4'b1110);
    go(2305); chk("blink_f2", enable, 4'b1111);
    go(3329); chk("blink_f3", enable, 4'b1111);
    go(4353); chk("blink_f4", enable, 4'b1101);
    go(5120); brightness = 4'd3;
    go(5121); chk("pwm3_0", enable, 4'b1110);
    go(5184); chk("pwm3_63", enable, 4'b1110);
    go(5185); chk("pwm3_64", enable, 4'b1111);
    go(5376); chk("pwm3_255", enable, 4'b1111);
    go(5377); chk("pwm3_d1", enable, 4'b1101); brightness = 4'd0;
    go(5392); chk("pwm0_15", enable, 4'b1101);
    go(5393); chk("pwm0_16", enable, 4'b1111);
    reset = 1'b1;
    @(negedge clk_disp);
    brightness = 4'd15;
    reset = 1'b0;
    k = 0;
    go(612);  chk("mid_idx", digit_idx, 2); chk("mid_en", enable, 4'b1011);
    reset = 1'b1;
    #1;
    chk("async_en", enable, 4'b1111);
    chk("async_sel", selected, 0);
    chk("async_idx", digit_idx, 0);
    @(negedge clk_disp);
    display_enable = 4'b0101;
    dp_in = 4'b1111;
    blink_mask = 4'b0000;
    reset = 1'b0;
    k = 0;
    go(1);    chk("de_d0", enable, 4'b1110); chk("de_d0_dp", dp_out, 1);
    go(257);  chk("de_d1", enable, 4'b1111); chk("de_d1_dp", dp_out, 0);
    go(513);  chk("de_d2", enable, 4'b1011); chk("de_d2_dp", dp_out, 1);
    go(769);  chk("de_d3", enable, 4'b1111); chk("de_d3_dp", dp_out, 0);
    go(1023); chk("rfs_pre", frame_start, 0);
    go(1024); chk("rfs", frame_start, 1);
    go(1025); display_enable = 4'b1111; values = 16'h0050;
    go(1026); chk("lz_d0", enable, 4'b1110); chk("lz_d0_sel", selected, 0);
    go(1281); chk("lz_d1", enable, 4'b1101); chk("lz_d1_sel", selected, 5);
`ifdef SEVEN_SEG_LZS_EN
    go(1537); chk("lz_d2", enable, 4'b1111); chk("lz_d2_dp", dp_out, 0);
    go(1793); chk("lz_d3", enable, 4'b1111);
`else
    go(1537); chk("lz_d2", enable, 4'b1011); chk("lz_d2_dp", dp_out, 1);
    go(1793); chk("lz_d3", enable, 4'b0111);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
